pong_buttons: RTL

Input-conditioning stage between the board push-buttons (btnU, btnD, btnL, btnR, btnC) and the pong game state machine and position logic. It synchronizes each raw button into the `clk` domain and debounces it. It then produces a clean level, one-cycle press and release pulses, and an auto-repeat pulse stream for held buttons. Downstream logic consumes pulses instead of raw pins, so a single physical press yields exactly one game event and a held paddle button yields a steady move rate.

---
 rtl/pong_buttons.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pong_buttons.sv
// Synchronizes, debounces and edge-detects push-buttons; masked buttons also auto-repeat while held.
// Level and pulses follow a stable raw change by DB_CYCLES+2 edges; no backpressure, all outputs are free-running.
module pong_buttons #(
  parameter int              NBTN       = 5,
  parameter int              DB_CYCLES  = 125000,
  parameter int              CNT_W      = 17,
  parameter int              RPT_DELAY  = 3125000,
  parameter int              RPT_PERIOD = 625000,
  parameter int              RPT_W      = 22,
  parameter logic [NBTN-1:0] RPT_MASK   = 5'b00011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_repeat
);

  typedef enum logic [1:0] {RPT_IDLE, RPT_WAIT, RPT_REPEAT} rpt_state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

  genvar i;
  for (i = 0; i < NBTN; i++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             level;
    logic             press;
    logic             rel;
    logic [CNT_W-1:0] dcnt;
    logic             accept;

    // A new level is accepted on the DB_CYCLES-th consecutive disagreeing cycle.
    assign accept = (s2 != level) && (dcnt == DB_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        dcnt  <= '0;
      end else begin
        s1    <= btn_raw[i];
        s2    <= s1;
        press <= accept & s2;
        rel   <= accept & ~s2;
        if (s2 == level || accept) dcnt <= '0;
        else                       dcnt <= dcnt + CNT_W'(1);
        if (accept) level <= s2;
      end
    end

    assign btn_level[i]   = level;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;

    if (RPT_MASK[i]) begin : g_rpt
      rpt_state_t       state;
      logic [RPT_W-1:0] rcnt;
      logic             rpt;

      // Keyed off the acceptance event so the first repeat coincides with the press pulse.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state <= RPT_IDLE;
          rcnt  <= '0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (accept && !s2) begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end else begin
            case (state)
              RPT_IDLE: begin
                rcnt <= '0;
                if (accept && s2) begin
                  rpt   <= 1'b1;
                  state <= RPT_WAIT;
                end
              end
              RPT_WAIT: begin
                if (rcnt == DELAY_LAST) begin
                  rpt   <= 1'b1;
                  rcnt  <= '0;
                  state <= RPT_REPEAT;
                end else begin
                  rcnt <= rcnt + RPT_W'(1);
                end
              end
              RPT_REPEAT: begin
                if (rcnt == PERIOD_LAST) begin
                  rpt  <= 1'b1;
                  rcnt <= '0;
                end else begin
                  rcnt <= rcnt + RPT_W'(1);
                end
              end
              default: begin
                state <= RPT_IDLE;
                rcnt  <= '0;
              end
            endcase
          end
        end
      end

      assign btn_repeat[i] = rpt;
    end else begin : g_norpt
      assign btn_repeat[i] = press;
    end
  end

endmodule
